// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C types and constants
//
// Purpose: sequencer state encoding, transfer-direction bits and the default
//          codec address shared by the I2C blocks.
// Ports:   none (package).
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_LOAD    = 3'd2,
      ST_SEND    = 3'd3,
      ST_RELEASE = 3'd4,
      ST_GAP     = 3'd5,
      ST_DONE    = 3'd6
   } seq_state_t;

   localparam logic I2C_MODE_WRITE = 1'b1;
   localparam logic I2C_MODE_READ  = 1'b0;

   localparam logic [6:0] I2C_CODEC_ADDR = 7'h1A;

endpackage

// File: rtl/i2c_gap_timer.sv
// rtl/i2c_gap_timer.sv - loadable down-counter with end-of-interval flag
//
// Purpose: counts an interval of i_load_val cycles starting the cycle after
//          i_load; o_expired is high during the final cycle of the interval.
// Ports:   i_clk, i_reset  - clock, synchronous active-high reset
//          i_load          - load i_load_val into the counter
//          i_load_val [W]  - interval length in cycles
//          o_expired       - high for one cycle: last cycle of the interval
module i2c_gap_timer #(
   parameter int W = 10
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_expired
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   // The count reaches 1 in the last cycle, so the owner can leave on this edge.
   assign o_expired = (r_cnt == W'(1));

endmodule

// File: rtl/i2c_init_sequencer.sv
// rtl/i2c_init_sequencer.sv - table-driven multi-byte I2C write sequencer
//
// Purpose: walks N_ENTRIES table words, sending each as one write transaction
//          through the byte-level I2C controller, with an idle gap after every
//          transaction and per-entry retry on NACK.
// Ports:   i_clk, i_reset           - clock, synchronous active-high reset
//          i_start                  - one-cycle run request (ignored while busy)
//          o_tbl_idx / i_tbl_word   - synchronous table ROM address / data
//          o_ctl_enable, o_ctl_mode, o_ctl_addr, o_ctl_byte, o_ctl_last
//                                   - byte request to the controller
//          i_ctl_ready, i_ctl_nack  - ACK-slot completion and its result
//          o_busy, o_done, o_error, o_fail_idx, o_state - status and debug
module i2c_init_sequencer
   import i2c_pkg::*;
#(
   parameter int         N_ENTRIES       = 11,
   parameter int         BYTES_PER_ENTRY = 2,
   parameter logic [6:0] PERIPH_ADDR     = I2C_CODEC_ADDR,
   parameter int         GAP_CYCLES      = 1000,
   parameter int         MAX_RETRIES     = 3,
   localparam int        IW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1,
   localparam int        DW = 8 * BYTES_PER_ENTRY
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_start,
   output logic [IW-1:0] o_tbl_idx,
   input  logic [DW-1:0] i_tbl_word,
   output logic          o_ctl_enable,
   output logic          o_ctl_mode,
   output logic [6:0]    o_ctl_addr,
   output logic [7:0]    o_ctl_byte,
   output logic          o_ctl_last,
   input  logic          i_ctl_ready,
   input  logic          i_ctl_nack,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_error,
   output logic [IW-1:0] o_fail_idx,
   output logic [2:0]    o_state
);

   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam int BW = (BYTES_PER_ENTRY > 1) ? $clog2(BYTES_PER_ENTRY) : 1;

   localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES_PER_ENTRY - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(N_ENTRIES - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
   localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES);

   seq_state_t    r_state;
   logic [IW-1:0] r_idx;
   logic [IW-1:0] r_fail_idx;
   logic [RW-1:0] r_retry_cnt;
   logic [BW-1:0] r_byte_cnt;
   logic [DW-1:0] r_shift;
   logic          r_nack_flag;
   logic          r_busy;
   logic          r_done;
   logic          r_error;
   logic          r_ctl_enable;

   logic          w_last_byte;
   logic          w_gap_load;
   logic          w_gap_expired;

   assign w_last_byte = (r_byte_cnt == LAST_BYTE);
   // The gap starts on the edge that closes a transaction (final ACK or any NACK).
   assign w_gap_load  = (r_state == ST_SEND) && i_ctl_ready && (i_ctl_nack || w_last_byte);

   i2c_gap_timer #(
      .W (GW)
   ) u_gap_timer (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_load     (w_gap_load),
      .i_load_val (GAP_LOAD),
      .o_expired  (w_gap_expired)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_idx        <= '0;
         r_fail_idx   <= '0;
         r_retry_cnt  <= '0;
         r_byte_cnt   <= '0;
         r_shift      <= '0;
         r_nack_flag  <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
         r_ctl_enable <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_idx       <= '0;
                  r_retry_cnt <= '0;
                  r_error     <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= ST_FETCH;
               end
            end
            // o_tbl_idx is r_idx, so the ROM sees the address during this cycle.
            ST_FETCH: begin
               r_state <= ST_LOAD;
            end
            ST_LOAD: begin
               r_shift      <= i_tbl_word;
               r_byte_cnt   <= '0;
               r_ctl_enable <= 1'b1;
               r_state      <= ST_SEND;
            end
            ST_SEND: begin
               if (i_ctl_ready) begin
                  r_ctl_enable <= 1'b0;
                  if (i_ctl_nack) begin
                     r_nack_flag <= 1'b1;
                     r_state     <= ST_GAP;
                  end else if (w_last_byte) begin
                     r_nack_flag <= 1'b0;
                     r_state     <= ST_GAP;
                  end else begin
                     r_shift    <= r_shift << 8;
                     r_byte_cnt <= r_byte_cnt + 1'b1;
                     r_state    <= ST_RELEASE;
                  end
               end
            end
            // One low cycle of enable marks the byte boundary for the controller.
            ST_RELEASE: begin
               r_ctl_enable <= 1'b1;
               r_state      <= ST_SEND;
            end
            ST_GAP: begin
               if (w_gap_expired) begin
                  if (r_nack_flag) begin
                     if (r_retry_cnt < RETRY_MAX) begin
                        r_retry_cnt <= r_retry_cnt + 1'b1;
                        r_state     <= ST_FETCH;
                     end else begin
                        r_error    <= 1'b1;
                        r_fail_idx <= r_idx;
                        r_done     <= 1'b1;
                        r_state    <= ST_DONE;
                     end
                  end else if (r_idx == LAST_IDX) begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_idx       <= r_idx + 1'b1;
                     r_retry_cnt <= '0;
                     r_state     <= ST_FETCH;
                  end
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_ctl_enable <= 1'b0;
               r_busy       <= 1'b0;
               r_state      <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_tbl_idx    = r_idx;
   assign o_ctl_enable = r_ctl_enable;
   assign o_ctl_mode   = I2C_MODE_WRITE;
   assign o_ctl_addr   = PERIPH_ADDR;
   assign o_ctl_byte   = r_shift[DW-1 -: 8];
   assign o_ctl_last   = r_ctl_enable && w_last_byte;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_error      = r_error;
   assign o_fail_idx   = r_fail_idx;
   assign o_state      = r_state;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// tb/tb_i2c_init_sequencer.sv - directed self-checking bench for i2c_init_sequencer
module tb_i2c_init_sequencer;
   import i2c_pkg::*;

   localparam int GAP = 4;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  tbl_idx;
   logic [15:0] tbl_word;
   logic        ctl_enable;
   logic        ctl_mode;
   logic [6:0]  ctl_addr;
   logic [7:0]  ctl_byte;
   logic        ctl_last;
   logic        ctl_ready;
   logic        ctl_nack;
   logic        busy;
   logic        done;
   logic        error;
   logic [1:0]  fail_idx;
   logic [2:0]  state;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;
   int fetch2_cnt = 0;
   int max_fetch_idx = 0;

   i2c_init_sequencer #(
      .N_ENTRIES       (3),
      .BYTES_PER_ENTRY (2),
      .PERIPH_ADDR     (7'h1A),
      .GAP_CYCLES      (GAP),
      .MAX_RETRIES     (3)
   ) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_start      (start),
      .o_tbl_idx    (tbl_idx),
      .i_tbl_word   (tbl_word),
      .o_ctl_enable (ctl_enable),
      .o_ctl_mode   (ctl_mode),
      .o_ctl_addr   (ctl_addr),
      .o_ctl_byte   (ctl_byte),
      .o_ctl_last   (ctl_last),
      .i_ctl_ready  (ctl_ready),
      .i_ctl_nack   (ctl_nack),
      .o_busy       (busy),
      .o_done       (done),
      .o_error      (error),
      .o_fail_idx   (fail_idx),
      .o_state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External synchronous table ROM.
   always_ff @(posedge clk) begin
      case (tbl_idx)
         2'd0:    tbl_word <= 16'h1E00;
         2'd1:    tbl_word <= 16'h0C00;
         2'd2:    tbl_word <= 16'h1201;
         default: tbl_word <= 16'hDEAD;
      endcase
   end

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (state == ST_FETCH) begin
         if (tbl_idx == 2'd2) fetch2_cnt++;
         if (int'(tbl_idx) > max_fetch_idx) max_fetch_idx = int'(tbl_idx);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Act as the controller for one byte: wait for the request, check it, ACK/NACK it.
   task automatic serve(input string tag, input logic [7:0] b, input logic last,
                        input logic nack, output int waited);
      waited = 0;
      while (!ctl_enable && waited < 50) begin
         tick();
         waited++;
      end
      chk({tag, "_enable"}, ctl_enable, 1'b1);
      chk({tag, "_byte"}, ctl_byte, b);
      chk({tag, "_last"}, ctl_last, last);
      tick();
      chk({tag, "_byte_stable"}, ctl_byte, b);
      ctl_ready = 1'b1;
      ctl_nack  = nack;
      tick();
      ctl_ready = 1'b0;
      ctl_nack  = 1'b0;
      chk({tag, "_enable_drop"}, ctl_enable, 1'b0);
      if (!last && !nack) chk({tag, "_state_release"}, state, ST_RELEASE);
      else                chk({tag, "_state_gap"}, state, ST_GAP);
   endtask

   task automatic measure_gap(input string tag);
      int n;
      n = 0;
      while (state == ST_GAP && n < 100) begin
         n++;
         tick();
      end
      chk({tag, "_gap_len"}, n, GAP);
   endtask

   task automatic entry_ack(input string tag, input logic [15:0] w);
      int wt;
      serve({tag, "_b0"}, w[15:8], 1'b0, 1'b0, wt);
      serve({tag, "_b1"}, w[7:0], 1'b1, 1'b0, wt);
      chk({tag, "_release_cycles"}, wt, 1);
      measure_gap(tag);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int wt;
      int base;
      reset = 1'b1;
      start = 1'b0;
      ctl_ready = 1'b0;
      ctl_nack  = 1'b0;
      repeat (3) tick();

      // Reset state
      chk("rst_state", state, ST_IDLE);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_error", error, 1'b0);
      chk("rst_enable", ctl_enable, 1'b0);
      chk("rst_last", ctl_last, 1'b0);
      chk("rst_byte", ctl_byte, 8'h00);
      chk("rst_tbl_idx", tbl_idx, 2'd0);
      chk("rst_fail_idx", fail_idx, 2'd0);
      chk("rst_mode", ctl_mode, 1'b1);
      chk("rst_addr", ctl_addr, 7'h1A);
      reset = 1'b0;
      tick();

      // Run 1: all ACK, start while busy and start in the done cycle both dropped
      pulse_start();
      chk("r1_busy", busy, 1'b1);
      chk("r1_fetch", state, ST_FETCH);
      serve("r1_e0_b0", 8'h1E, 1'b0, 1'b0, wt);
      chk("r1_start_to_enable", wt + 1, 3);
      serve("r1_e0_b1", 8'h00, 1'b1, 1'b0, wt);
      chk("r1_release_cycles", wt, 1);
      measure_gap("r1_e0");
      serve("r1_e1_b0", 8'h0C, 1'b0, 1'b0, wt);
      chk("r1_gap_to_send", wt, 2);
      pulse_start();
      serve("r1_e1_b1", 8'h00, 1'b1, 1'b0, wt);
      measure_gap("r1_e1");
      entry_ack("r1_e2", 16'h1201);
      chk("r1_done_state", state, ST_DONE);
      chk("r1_done", done, 1'b1);
      chk("r1_error", error, 1'b0);
      pulse_start();
      chk("r1_idle_after_done", state, ST_IDLE);
      chk("r1_busy_after_done", busy, 1'b0);
      repeat (4) tick();
      chk("r1_still_idle", state, ST_IDLE);
      chk("r1_done_count", done_cnt, 1);

      // Run 2: entry 1 NACKs on byte 0 once, then succeeds
      pulse_start();
      entry_ack("r2_e0", 16'h1E00);
      serve("r2_e1_nack", 8'h0C, 1'b0, 1'b1, wt);
      measure_gap("r2_e1_nack");
      chk("r2_refetch_state", state, ST_FETCH);
      chk("r2_refetch_idx", tbl_idx, 2'd1);
      entry_ack("r2_e1", 16'h0C00);
      entry_ack("r2_e2", 16'h1201);
      chk("r2_done", done, 1'b1);
      chk("r2_error", error, 1'b0);
      tick();

      // Run 3: entry 2 always NACKs -> 4 attempts then error
      pulse_start();
      base = fetch2_cnt;
      entry_ack("r3_e0", 16'h1E00);
      entry_ack("r3_e1", 16'h0C00);
      for (int a = 0; a < 4; a++) begin
         serve("r3_e2_nack", 8'h12, 1'b0, 1'b1, wt);
         measure_gap("r3_e2");
         if (a < 3) begin
            chk("r3_retry_fetch", state, ST_FETCH);
            chk("r3_retry_idx", tbl_idx, 2'd2);
         end
      end
      chk("r3_done_state", state, ST_DONE);
      chk("r3_done", done, 1'b1);
      chk("r3_error", error, 1'b1);
      chk("r3_fail_idx", fail_idx, 2'd2);
      tick();
      tick();
      chk("r3_error_held", error, 1'b1);
      chk("r3_idle", state, ST_IDLE);
      chk("r3_attempts", fetch2_cnt - base, 4);
      chk("r3_max_fetch_idx", max_fetch_idx, 2);

      // Run 4: reset mid-SEND, then a fresh run from entry 0
      pulse_start();
      chk("r4_error_cleared", error, 1'b0);
      serve("r4_e0_b0", 8'h1E, 1'b0, 1'b0, wt);
      tick();
      chk("r4_midsend_enable", ctl_enable, 1'b1);
      chk("r4_midsend_byte", ctl_byte, 8'h00);
      reset = 1'b1;
      tick();
      chk("r4_rst_enable", ctl_enable, 1'b0);
      chk("r4_rst_state", state, ST_IDLE);
      chk("r4_rst_busy", busy, 1'b0);
      reset = 1'b0;
      tick();
      pulse_start();
      chk("r4_restart_state", state, ST_FETCH);
      chk("r4_restart_idx", tbl_idx, 2'd0);
      entry_ack("r4_e0", 16'h1E00);
      entry_ack("r4_e1", 16'h0C00);
      entry_ack("r4_e2", 16'h1201);
      chk("r4_done", done, 1'b1);
      chk("r4_error", error, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
